// File: rtl/synchronous_subtractor_pkg.sv
// synchronous_subtractor_pkg: shared state type, mode constants and default width
package synchronous_subtractor_pkg;
    localparam int   DEFAULT_WIDTH = 4;
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_RELOAD   = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/synchronous_subtractor.sv
// synchronous_subtractor: loadable down counter with borrow pulse and one-shot/auto-reload modes
module synchronous_subtractor
    import synchronous_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             mode,
    output logic [WIDTH-1:0] counter,
    output logic             borrow,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;

    // next state: load wins, then decrement or underflow while running and enabled
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        reload_d  = reload_q;
        borrow_d  = 1'b0;
        if (load) begin
            counter_d = load_value;
            reload_d  = load_value;
            state_d   = RUN;
        end else if (state_q == RUN && enable) begin
            if (counter_q != '0) begin
                counter_d = counter_q - WIDTH'(1);
            end else begin
                borrow_d  = 1'b1;
                counter_d = (mode == MODE_RELOAD) ? reload_q : counter_q;
                state_d   = (mode == MODE_ONESHOT) ? DONE : RUN;
            end
        end
    end

    // state, count, reload and borrow registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            reload_q  <= '0;
            borrow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            reload_q  <= reload_d;
            borrow_q  <= borrow_d;
        end
    end

    assign counter = counter_q;
    assign borrow  = borrow_q;
    assign busy    = (state_q == RUN);
endmodule
